// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg: shared constants and sizing helper for the
// slide-switch conditioning stage.
package switch_conditioner_pkg;

    // Default number of switch bits, equal to the PIO in_port width.
    localparam int SWC_WIDTH               = 10;
    // 20 ms of required stability at a 50 MHz clk.
    localparam int SWC_DEBOUNCE_CYCLES     = 1000000;
    // Short debounce window so simulations finish quickly.
    localparam int SWC_DEBOUNCE_CYCLES_SIM = 4;

    // Smallest r with 2**r >= value; sizes the per-bit debounce counter.
    function automatic int swc_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: two-flop synchroniser, debounce counter, clean level
// flop and one-cycle change strobe for a single switch bit.
module switch_debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES,
    parameter int CNT_W           = swc_clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             changed_q;
    logic             changed_d;

    // Bring the raw pin into the clk domain; only s2 is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw_raw;
            s2_q <= s1_q;
        end
    end

    // Count consecutive mismatching cycles; accept the new level at the cap.
    always_comb begin
        cnt_d     = '0;
        clean_d   = clean_q;
        changed_d = 1'b0;
        if (s2_q != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                clean_d   = s2_q;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state register; reset discards any partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            clean_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            changed_q <= changed_d;
        end
    end

    assign sw_clean   = clean_q;
    assign sw_changed = changed_q;

endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises and debounces the board slide switches,
// one independent switch_debounce_bit per bit. Defining
// SWITCH_CONDITIONER_EDGE_CAPTURE_EN adds sticky write-one-to-clear change
// flags (edge_capture) and an irq that is high while any flag is set.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int WIDTH           = SWC_WIDTH,
    parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    output logic [WIDTH-1:0] sw_changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
`else
    output logic [WIDTH-1:0] sw_changed
`endif
);

    localparam int CNT_W = swc_clog2(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .sw_raw    (sw_raw[i]),
            .sw_clean  (sw_clean[i]),
            .sw_changed(sw_changed[i])
        );
    end

`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic             irq_q;
    logic             irq_d;

    // A new strobe wins over a clear arriving in the same cycle.
    always_comb begin
        edge_d = (edge_q & ~edge_clear) | sw_changed;
        irq_d  = |edge_d;
    end

    // Sticky flags and irq register together so irq tracks edge_capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    assign edge_capture = edge_q;
    assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and randomized stimulus compared every
// cycle against a sliding-window model of the debounce rule.
module tb_switch_conditioner;
    import switch_conditioner_pkg::*;

    localparam int W = SWC_WIDTH;
    localparam int D = SWC_DEBOUNCE_CYCLES_SIM;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    logic [W-1:0] edge_clear;
    logic [W-1:0] edge_capture;
    logic         irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    switch_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_raw      (sw_raw),
        .sw_clean    (sw_clean),
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
        .sw_changed  (sw_changed),
        .edge_clear  (edge_clear),
        .edge_capture(edge_capture),
        .irq         (irq)
`else
        .sw_changed  (sw_changed)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bit's clean level flips when the last D synchronised samples
    // (raw delayed by two edges) all differ from it.
    logic [W-1:0] s1m, s2m, s2_old, cln, chg;
    logic [W-1:0] hist [D];
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    logic [W-1:0] cap;
    logic         irqm;
`endif

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                s1m = '0; s2m = '0; cln = '0; chg = '0;
                for (int j = 0; j < D; j++) hist[j] = '0;
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
                cap = '0; irqm = 1'b0;
`endif
            end else begin
                s2_old = s2m;
                s2m    = s1m;
                s1m    = sw_raw;
                for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = s2_old;
                chg = '0;
                for (int i = 0; i < W; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++) if (hist[j][i] == cln[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        cln[i] = ~cln[i];
                        chg[i] = 1'b1;
                    end
                end
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
                cap  = (cap & ~edge_clear) | chg;
                irqm = |cap;
`endif
            end
            #1;
            chk("model_sw_clean", sw_clean, cln);
            chk("model_sw_changed", sw_changed, chg);
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
            chk("model_edge_capture", edge_capture, cap);
            chk("model_irq", W'(irq), W'(irqm));
`endif
        end
    end

    task automatic edges_then_check(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        sw_raw  = '0;
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
        edge_clear = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_clean", sw_clean, 10'h000);
        chk("reset_changed", sw_changed, 10'h000);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // bit0 rise: accepted on the sixth edge after the first s1 sample
        sw_raw = 10'h001;
        edges_then_check(5);
        chk("bit0_edge5_clean", sw_clean, 10'h000);
        edges_then_check(1);
        chk("bit0_edge6_clean", sw_clean, 10'h001);
        chk("bit0_edge6_changed", sw_changed, 10'h001);
        edges_then_check(1);
        chk("bit0_edge7_changed", sw_changed, 10'h000);

        // reset mid-count while bit0 mismatches
        @(negedge clk);
        sw_raw = 10'h000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_clean", sw_clean, 10'h000);
        chk("midreset_changed", sw_changed, 10'h000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // bit3 bounce: high 3, low 1, then held high
        sw_raw = 10'h008;
        repeat (3) @(negedge clk);
        sw_raw = 10'h000;
        @(negedge clk);
        sw_raw = 10'h008;
        edges_then_check(5);
        chk("bounce_edge5_clean", sw_clean, 10'h000);
        edges_then_check(1);
        chk("bounce_edge6_clean", sw_clean, 10'h008);
        chk("bounce_edge6_changed", sw_changed, 10'h008);

        @(negedge clk);
        sw_raw = 10'h000;
        repeat (10) @(negedge clk);

        // all bits toggle together
        sw_raw = 10'h3FF;
        edges_then_check(5);
        chk("all_edge5_changed", sw_changed, 10'h000);
        edges_then_check(1);
        chk("all_edge6_clean", sw_clean, 10'h3FF);
        chk("all_edge6_changed", sw_changed, 10'h3FF);
        edges_then_check(1);
        chk("all_edge7_changed", sw_changed, 10'h000);

        // switches held through reset deassertion
        @(negedge clk);
        reset_n = 1'b0;
        sw_raw  = 10'h2A5;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        edges_then_check(5);
        chk("hold_edge5_clean", sw_clean, 10'h000);
        edges_then_check(1);
        chk("hold_edge6_clean", sw_clean, 10'h2A5);
        chk("hold_edge6_changed", sw_changed, 10'h2A5);

        // randomized bouncing with quiet windows and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 599) != 0);
            if ((cyc % 64) < 40) begin
                sw_raw = sw_raw ^ W'($urandom & $urandom & $urandom);
            end
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
            edge_clear = W'($urandom & $urandom);
`endif
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
